fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- IF-stage PC generator and IF/ID pipeline register.
- Consumes the predictor's pred_taken/pred_target in IF and carries the prediction into ID.
- In ID, checks the resolved control flow (the same cflow_* signals that update the predictor) against that prediction. On a mismatch it raises a redirect and squashes the wrong-path instruction.
- Also holds control-flow and mispredict performance counters.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction placed in ID on bubble or flush (addi x0,x0,0).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
stall_f  in  1  hold pc_f.
stall_d  in  1  hold the IF/ID register.
flush_d  in  1  external squash of the ID slot (trap, fence).
pc_f  out  32  current fetch PC; drives the predictor and imem.
pred_taken  in  1  predictor taken, combinational on pc_f.
pred_target  in  32  predictor target for pc_f.
instr_f  in  32  imem data for pc_f, same cycle.
valid_d  out  1  ID slot holds a real instruction.
instr_d  out  32  ID instruction.
pc_d  out  32  ID PC; drives predictor update.
pc_plus4_d  out  32  pc_d + 4.
pred_taken_d  out  1  prediction carried with the ID instruction.
cflow_valid  in  1  ID instruction is a branch or jump.
cflow_taken  in  1  resolved direction.
cflow_target  in  32  resolved target.
redirect  out  1  mispredict, combinational in ID.
redirect_pc  out  32  correct next PC.
perf_cflow_cnt  out  CNT_W  resolved control-flow instructions.
perf_mispred_cnt  out  CNT_W  mispredicts.

Behaviour:
- Reset (asynchronous): all outputs below take these values immediately and hold until the first clock edge after reset deasserts.
  - pc_f=RESET_PC, valid_d=0, instr_d=NOP_INSTR.
  - pc_d=0, pc_plus4_d=4, pred_taken_d=0, pred_target_d=0.
  - Both counters 0; redirect=0.
- Resolution in ID:
  - res_ok = valid_d && !stall_d && !flush_d.
  - actual_taken = cflow_valid && cflow_taken.
  - Mispredict when res_ok and either:
    - actual_taken && !(pred_taken_d && pred_target_d==cflow_target), or
    - !actual_taken && pred_taken_d. This covers predicted-taken non-branches (BTB alias).
  - redirect = mispredict.
  - redirect_pc = actual_taken ? cflow_target : pc_plus4_d.
- Next-PC selection, highest priority first:
  - redirect → redirect_pc.
  - stall_f → hold pc_f.
  - pred_taken → pred_target.
  - else pc_f+4.
  - Adds are 32-bit and wrap modulo 2^32 (0xFFFF_FFFC+4 → 0).
- IF/ID register update, highest priority first:
  - flush_d or redirect → bubble: valid_d=0, instr_d=NOP_INSTR, pred_taken_d=0.
  - stall_d → hold all fields.
  - else load: valid_d=1, instr_f, pc_f, pc_f+4, pred_taken, pred_target.
- Latency:
  - Redirect is visible on pc_f one cycle after the mispredict cycle.
  - Exactly one wrong-path instruction (the one in IF) is squashed.
- Redirect during stall_f: redirect wins and stall_f is ignored that cycle.
- Redirect during stall_d: impossible by construction, since res_ok requires !stall_d.
- Counters:
  - perf_cflow_cnt increments on res_ok && cflow_valid.
  - perf_mispred_cnt increments on redirect.
  - Both wrap at 2^CNT_W and never saturate.
- Reset mid-stall or mid-redirect: reset dominates; pc_f returns to RESET_PC and no pending redirect survives.

Decomposition:
- riscv_defines: RESET_PC and NOP_INSTR constants; typedef if_id_t struct {valid, instr, pc, pc_plus4, pred_taken, pred_target}.
- One sub-module, cflow_resolve_check: combinational; inputs are the if_id_t fields plus cflow_*; outputs redirect and redirect_pc. Separated so it can be unit-tested alone.

Test Plan:
- Reset release with no stalls, pred_taken=0:
  - pc_f sequence 0x0, 0x4, 0x8.
  - valid_d=0 first cycle, then 1 with pc_d=0x0.
- pred_taken=1, pred_target=0x100 at pc_f=0x8:
  - Next pc_f=0x100.
  - In ID, pc_d=0x8, cflow_taken=1, cflow_target=0x100 → no redirect; perf_cflow_cnt=1.
- Predicted taken to 0x100 but resolved not-taken:
  - redirect=1, redirect_pc=0xC.
  - Next pc_f=0xC; valid_d=0, instr_d=0x13.
  - perf_mispred_cnt=1.
- Predicted taken, resolved taken to 0x200 (target mismatch): redirect_pc=0x200, perf_mispred_cnt increments.
- stall_f=1 and stall_d=1 for 3 cycles:
  - pc_f, pc_d, instr_d held.
  - No counter change even with cflow_valid=1.
  - Then flush_d=1 → valid_d=0, redirect=0.
- pc_f=0xFFFF_FFFC, no prediction: next pc_f=0x0. Asserting reset asynchronously mid-cycle sets pc_f=RESET_PC immediately.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared constants and the IF/ID pipeline register layout for the fetch unit.
package riscv_defines;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        pred_taken;
        logic [31:0] pred_target;
    } if_id_t;

endpackage

// File: rtl/cflow_resolve_check.sv
// Combinational ID-stage check of the resolved control flow against the
// prediction carried with the instruction.
module cflow_resolve_check (
    input  logic        valid,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic [31:0] pc_plus4,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic        cflow_valid,
    input  logic        cflow_taken,
    input  logic [31:0] cflow_target,
    output logic        res_ok,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    logic actual_taken;

    // A predicted-taken non-branch (BTB alias) also counts as a mispredict.
    always_comb begin
        res_ok       = valid && !stall_d && !flush_d;
        actual_taken = cflow_valid && cflow_taken;
        redirect     = 1'b0;
        if (res_ok) begin
            if (actual_taken)
                redirect = !(pred_taken && (pred_target == cflow_target));
            else
                redirect = pred_taken;
        end
        redirect_pc = actual_taken ? cflow_target : pc_plus4;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator, IF/ID pipeline register, mispredict redirect and
// control-flow performance counters.
module fetch_pc_unit
    import riscv_defines::*;
#(
    parameter logic [31:0] RESET_PC  = riscv_defines::RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_defines::NOP_INSTR,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             flush_d,
    output logic [31:0]      pc_f,
    input  logic             pred_taken,
    input  logic [31:0]      pred_target,
    input  logic [31:0]      instr_f,
    output logic             valid_d,
    output logic [31:0]      instr_d,
    output logic [31:0]      pc_d,
    output logic [31:0]      pc_plus4_d,
    output logic             pred_taken_d,
    input  logic             cflow_valid,
    input  logic             cflow_taken,
    input  logic [31:0]      cflow_target,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] perf_cflow_cnt,
    output logic [CNT_W-1:0] perf_mispred_cnt
);

    if_id_t      if_id;
    logic        res_ok;
    logic [31:0] pc_f_plus4;
    logic [31:0] pc_next;

    assign pc_f_plus4 = pc_f + 32'd4;

    cflow_resolve_check u_check (
        .valid        (if_id.valid),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .pc_plus4     (if_id.pc_plus4),
        .pred_taken   (if_id.pred_taken),
        .pred_target  (if_id.pred_target),
        .cflow_valid  (cflow_valid),
        .cflow_taken  (cflow_taken),
        .cflow_target (cflow_target),
        .res_ok       (res_ok),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    // A redirect overrides stall_f so the squash costs exactly one slot.
    always_comb begin
        pc_next = pc_f_plus4;
        if (redirect)
            pc_next = redirect_pc;
        else if (stall_f)
            pc_next = pc_f;
        else if (pred_taken)
            pc_next = pred_target;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_f <= RESET_PC;
        else
            pc_f <= pc_next;
    end

    // Bubbles keep the PC fields so the ID slot still names a sane address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id.valid       <= 1'b0;
            if_id.instr       <= NOP_INSTR;
            if_id.pc          <= 32'h0000_0000;
            if_id.pc_plus4    <= 32'h0000_0004;
            if_id.pred_taken  <= 1'b0;
            if_id.pred_target <= 32'h0000_0000;
        end else if (flush_d || redirect) begin
            if_id.valid       <= 1'b0;
            if_id.instr       <= NOP_INSTR;
            if_id.pred_taken  <= 1'b0;
        end else if (!stall_d) begin
            if_id.valid       <= 1'b1;
            if_id.instr       <= instr_f;
            if_id.pc          <= pc_f;
            if_id.pc_plus4    <= pc_f_plus4;
            if_id.pred_taken  <= pred_taken;
            if_id.pred_target <= pred_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cflow_cnt   <= '0;
            perf_mispred_cnt <= '0;
        end else begin
            if (res_ok && cflow_valid)
                perf_cflow_cnt <= perf_cflow_cnt + 1'b1;
            if (redirect)
                perf_mispred_cnt <= perf_mispred_cnt + 1'b1;
        end
    end

    assign valid_d      = if_id.valid;
    assign instr_d      = if_id.instr;
    assign pc_d         = if_id.pc;
    assign pc_plus4_d   = if_id.pc_plus4;
    assign pred_taken_d = if_id.pred_taken;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f, stall_d, flush_d;
    logic [31:0] pc_f;
    logic        pred_taken;
    logic [31:0] pred_target, instr_f;
    logic        valid_d;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        pred_taken_d;
    logic        cflow_valid, cflow_taken;
    logic [31:0] cflow_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] perf_cflow_cnt, perf_mispred_cnt;

    int errors = 0;
    int checks = 0;

    fetch_pc_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall_f          (stall_f),
        .stall_d          (stall_d),
        .flush_d          (flush_d),
        .pc_f             (pc_f),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .instr_f          (instr_f),
        .valid_d          (valid_d),
        .instr_d          (instr_d),
        .pc_d             (pc_d),
        .pc_plus4_d       (pc_plus4_d),
        .pred_taken_d     (pred_taken_d),
        .cflow_valid      (cflow_valid),
        .cflow_taken      (cflow_taken),
        .cflow_target     (cflow_target),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .perf_cflow_cnt   (perf_cflow_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic pt, input logic [31:0] ptgt, input logic [31:0] instr,
                                 input logic cv, input logic ct, input logic [31:0] ctgt);
        pred_taken   = pt;
        pred_target  = ptgt;
        instr_f      = instr;
        cflow_valid  = cv;
        cflow_taken  = ct;
        cflow_target = ctgt;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pred_taken = 1'b0; pred_target = '0; instr_f = '0;
        cflow_valid = 1'b0; cflow_taken = 1'b0; cflow_target = '0;
        #3;
        checkOutput("rst_pc_f", pc_f, 32'h0);
        checkOutput("rst_valid_d", {31'b0, valid_d}, 32'h0);
        checkOutput("rst_instr_d", instr_d, 32'h13);
        checkOutput("rst_pc_d", pc_d, 32'h0);
        checkOutput("rst_pc_plus4_d", pc_plus4_d, 32'h4);
        checkOutput("rst_pred_taken_d", {31'b0, pred_taken_d}, 32'h0);
        checkOutput("rst_redirect", {31'b0, redirect}, 32'h0);
        checkOutput("rst_cflow_cnt", perf_cflow_cnt, 32'h0);
        checkOutput("rst_mispred_cnt", perf_mispred_cnt, 32'h0);

        #9;
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h1111_0000, 1'b0, 1'b0, 32'h0);
        checkOutput("seq_pc0", pc_f, 32'h0);
        checkOutput("seq_valid0", {31'b0, valid_d}, 32'h0);

        tick();
        checkOutput("seq_pc4", pc_f, 32'h4);
        checkOutput("seq_valid1", {31'b0, valid_d}, 32'h1);
        checkOutput("seq_pc_d0", pc_d, 32'h0);
        checkOutput("seq_instr_d0", instr_d, 32'h1111_0000);
        applyStimulus(1'b0, 32'h0, 32'h1111_0004, 1'b0, 1'b0, 32'h0);

        tick();
        checkOutput("seq_pc8", pc_f, 32'h8);
        checkOutput("seq_pc_d4", pc_d, 32'h4);
        applyStimulus(1'b1, 32'h100, 32'h1111_0008, 1'b0, 1'b0, 32'h0);

        tick();
        checkOutput("pred_pc_f", pc_f, 32'h100);
        checkOutput("pred_pc_d", pc_d, 32'h8);
        checkOutput("pred_taken_d", {31'b0, pred_taken_d}, 32'h1);
        applyStimulus(1'b0, 32'h0, 32'h2222_0100, 1'b1, 1'b1, 32'h100);
        checkOutput("pred_ok_redirect", {31'b0, redirect}, 32'h0);

        tick();
        checkOutput("pred_ok_cflow_cnt", perf_cflow_cnt, 32'h1);
        checkOutput("pred_ok_mispred_cnt", perf_mispred_cnt, 32'h0);
        checkOutput("pred_ok_pc_f", pc_f, 32'h104);
        applyStimulus(1'b1, 32'h100, 32'h2222_0104, 1'b0, 1'b0, 32'h0);

        tick();
        checkOutput("nt_pc_d", pc_d, 32'h104);
        applyStimulus(1'b0, 32'h0, 32'h3333_0100, 1'b1, 1'b0, 32'h0);
        checkOutput("nt_redirect", {31'b0, redirect}, 32'h1);
        checkOutput("nt_redirect_pc", redirect_pc, 32'h108);

        tick();
        checkOutput("nt_pc_f", pc_f, 32'h108);
        checkOutput("nt_squash_valid", {31'b0, valid_d}, 32'h0);
        checkOutput("nt_squash_instr", instr_d, 32'h13);
        checkOutput("nt_mispred_cnt", perf_mispred_cnt, 32'h1);
        checkOutput("nt_cflow_cnt", perf_cflow_cnt, 32'h2);
        applyStimulus(1'b1, 32'h300, 32'h4444_0108, 1'b0, 1'b0, 32'h0);

        tick();
        checkOutput("tm_pc_f", pc_f, 32'h300);
        checkOutput("tm_pc_d", pc_d, 32'h108);
        stall_f = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h5555_0300, 1'b1, 1'b1, 32'h200);
        checkOutput("tm_redirect", {31'b0, redirect}, 32'h1);
        checkOutput("tm_redirect_pc", redirect_pc, 32'h200);

        tick();
        checkOutput("tm_pc_f_over_stall", pc_f, 32'h200);
        checkOutput("tm_mispred_cnt", perf_mispred_cnt, 32'h2);
        checkOutput("tm_cflow_cnt", perf_cflow_cnt, 32'h3);
        stall_f = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h6666_0200, 1'b0, 1'b0, 32'h0);

        tick();
        checkOutput("st_pre_pc_f", pc_f, 32'h204);
        checkOutput("st_pre_pc_d", pc_d, 32'h200);
        stall_f = 1'b1;
        stall_d = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h7777_0204, 1'b1, 1'b1, 32'h500);
        checkOutput("st_redirect", {31'b0, redirect}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("st_pc_f", pc_f, 32'h204);
            checkOutput("st_pc_d", pc_d, 32'h200);
            checkOutput("st_instr_d", instr_d, 32'h6666_0200);
            checkOutput("st_cflow_cnt", perf_cflow_cnt, 32'h3);
            checkOutput("st_mispred_cnt", perf_mispred_cnt, 32'h2);
        end
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b1;
        #1;
        checkOutput("fl_redirect", {31'b0, redirect}, 32'h0);

        tick();
        checkOutput("fl_valid_d", {31'b0, valid_d}, 32'h0);
        checkOutput("fl_instr_d", instr_d, 32'h13);
        checkOutput("fl_pc_f", pc_f, 32'h208);
        checkOutput("fl_cflow_cnt", perf_cflow_cnt, 32'h3);
        flush_d = 1'b0;
        applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h8888_0208, 1'b0, 1'b0, 32'h0);

        tick();
        checkOutput("wr_pc_f_top", pc_f, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 32'h9999_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFC);
        checkOutput("wr_redirect", {31'b0, redirect}, 32'h0);

        tick();
        checkOutput("wr_pc_f_wrap", pc_f, 32'h0);
        checkOutput("wr_pc_d", pc_d, 32'hFFFF_FFFC);
        checkOutput("wr_pc_plus4_d", pc_plus4_d, 32'h0);
        checkOutput("wr_cflow_cnt", perf_cflow_cnt, 32'h4);
        applyStimulus(1'b0, 32'h0, 32'hAAAA_0000, 1'b0, 1'b0, 32'h0);

        tick();
        checkOutput("ar_pre_pc_f", pc_f, 32'h4);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_pc_f", pc_f, 32'h0);
        checkOutput("ar_valid_d", {31'b0, valid_d}, 32'h0);
        checkOutput("ar_pc_d", pc_d, 32'h0);
        checkOutput("ar_cflow_cnt", perf_cflow_cnt, 32'h0);
        checkOutput("ar_mispred_cnt", perf_mispred_cnt, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
